// File: rtl/store_buffer.sv
// store_buffer: circular FIFO of committed stores drained oldest-first into the D$,
// with a combinational youngest-match search for load forwarding and overlap stalls.
module store_buffer #(
    parameter int SB_DEPTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        push_valid,
    input  logic [ADDR_WIDTH-1:0]       push_addr,
    input  logic [1:0]                  push_size,
    input  logic [DATA_WIDTH-1:0]       push_data,
    output logic                        push_ready,
    output logic                        buffer_empty,
    output logic                        buffer_full,
    output logic [$clog2(SB_DEPTH):0]   sb_count,
    input  logic                        get_oldest,
    output logic                        oldest_valid,
    output logic [ADDR_WIDTH-1:0]       oldest_addr,
    output logic [1:0]                  oldest_size,
    output logic [DATA_WIDTH-1:0]       oldest_data,
    input  logic                        fwd_req,
    input  logic [ADDR_WIDTH-1:0]       fwd_addr,
    input  logic [1:0]                  fwd_size,
    output logic                        fwd_hit,
    output logic [DATA_WIDTH-1:0]       fwd_data,
    output logic                        fwd_conflict
);
    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] addr_q [SB_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d [SB_DEPTH];
    logic [1:0]            size_q [SB_DEPTH];
    logic [1:0]            size_d [SB_DEPTH];
    logic [DATA_WIDTH-1:0] data_q [SB_DEPTH];
    logic [DATA_WIDTH-1:0] data_d [SB_DEPTH];
    logic [SB_DEPTH-1:0]   valid_q, valid_d;
    logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push_acc, pop_acc;
    logic                  found;
    logic [PW-1:0]         sel;

    // Size 3 is treated as a full word.
    function automatic logic [2:0] nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 3'd1 : (s == 2'd1) ? 3'd2 : 3'd4;
    endfunction

    function automatic logic overlap(input logic [ADDR_WIDTH-1:0] a, input logic [1:0] as,
                                     input logic [ADDR_WIDTH-1:0] b, input logic [1:0] bs);
        logic [2:0] ao;
        logic [2:0] bo;
        ao = {1'b0, a[1:0]};
        bo = {1'b0, b[1:0]};
        return (a[ADDR_WIDTH-1:2] == b[ADDR_WIDTH-1:2]) && (ao < bo + nbytes(bs)) && (bo < ao + nbytes(as));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] size_mask(input logic [1:0] s);
        return (s == 2'd0) ? DATA_WIDTH'(8'hff) : (s == 2'd1) ? DATA_WIDTH'(16'hffff) : '1;
    endfunction

    assign buffer_empty = (count_q == '0);
    assign buffer_full  = (count_q == CW'(SB_DEPTH));
    assign push_ready   = !buffer_full;
    assign oldest_valid = !buffer_empty;
    assign sb_count     = count_q;
    assign push_acc     = push_valid && push_ready;
    assign pop_acc      = get_oldest && oldest_valid;
    assign oldest_addr  = oldest_valid ? addr_q[head_q] : '0;
    assign oldest_size  = oldest_valid ? size_q[head_q] : '0;
    assign oldest_data  = oldest_valid ? data_q[head_q] : '0;

    always_comb begin
        addr_d  = addr_q;
        size_d  = size_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (push_acc) begin
            addr_d[tail_q]  = push_addr;
            size_d[tail_q]  = push_size;
            data_d[tail_q]  = push_data;
            valid_d[tail_q] = 1'b1;
        end
        if (pop_acc)
            valid_d[head_q] = 1'b0;
        head_d  = head_q + PW'(pop_acc);
        tail_d  = tail_q + PW'(push_acc);
        count_d = count_q + CW'(push_acc) - CW'(pop_acc);
    end

    // Walk oldest to youngest so the last overlapping entry found is the youngest.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (valid_q[head_q + PW'(i)] &&
                overlap(addr_q[head_q + PW'(i)], size_q[head_q + PW'(i)], fwd_addr, fwd_size)) begin
                found = 1'b1;
                sel   = head_q + PW'(i);
            end
        end
        fwd_hit      = fwd_req && found && (addr_q[sel] == fwd_addr) && (size_q[sel] == fwd_size);
        fwd_conflict = fwd_req && found && !fwd_hit;
        fwd_data     = fwd_hit ? (data_q[sel] & size_mask(fwd_size)) : '0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q  <= '{default: '0};
            size_q  <= '{default: '0};
            data_q  <= '{default: '0};
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            size_q  <= size_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule
